dcache_responder: RTL and testbench

- Responder side of the MEM-stage data-memory port.
- Accepts word-addressed loads (rin/rd_en) and stores (we/waddr/win) from the memory stage.
- Direct-mapped, write-through, no-write-allocate cache that refills 4-word lines from backing memory over a req/ack handshake.
- Raises stall while a miss or write-through is outstanding.

---
 rtl/dcache_pkg.sv | 26 ++
 rtl/dcache_line_store.sv | 76 +++++++
 rtl/dcache_responder.sv | 171 +++++++++++++++++
 tb/tb_dcache_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the data-cache responder.
// Optional build macro used by dcache_responder: DCACHE_STATS_EN (load hit/miss counters).
package dcache_pkg;

  localparam int DC_ADDR_W = 16;
  localparam int DC_DATA_W = 32;
  localparam int DC_LINES  = 64;
  localparam int DC_WPL    = 4;

  // Derived field widths of a word address: {tag, index, offset}
  localparam int DC_IDX_W  = $clog2(DC_LINES);
  localparam int DC_OFF_W  = $clog2(DC_WPL);
  localparam int DC_TAG_W  = DC_ADDR_W - DC_IDX_W - DC_OFF_W;

  // Bit positions of the index and tag fields inside a word address
  localparam int DC_IDX_LSB = DC_OFF_W;
  localparam int DC_TAG_LSB = DC_OFF_W + DC_IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WTHRU  = 2'd1,
    REFILL = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_line_store.sv
// Tag, valid and data storage of the direct-mapped cache.
// One lookup address drives the tag compare and the registered word read.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int ADDR_W = DC_ADDR_W,
  parameter int DATA_W = DC_DATA_W,
  parameter int LINES  = DC_LINES,
  parameter int WPL    = DC_WPL,
  localparam int IDX_W = $clog2(LINES),
  localparam int OFF_W = $clog2(WPL),
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      lk_addr,
  output logic                   hit,
  input  logic                   rd_stb,
  output logic [DATA_W-1:0]      rd_data,
  input  logic                   wr_en,
  input  logic [IDX_W+OFF_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   tag_set,
  input  logic                   tag_inval,
  input  logic [IDX_W-1:0]       line_idx,
  input  logic [TAG_W-1:0]       line_tag
);

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES*WPL];
  logic [LINES-1:0]  valid_reg;
  logic [DATA_W-1:0] rd_data_reg;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;

  assign lk_idx  = lk_addr[OFF_W +: IDX_W];
  assign lk_tag  = lk_addr[OFF_W+IDX_W +: TAG_W];
  assign hit     = valid_reg[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign rd_data = rd_data_reg;

  // Valid bits: cleared by reset, set when a refill completes, dropped when a refill starts
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= '0;
    end else if (tag_set) begin
      valid_reg[line_idx] <= 1'b1;
    end else if (tag_inval) begin
      valid_reg[line_idx] <= 1'b0;
    end
  end

  // Tag array write on refill completion
  always_ff @(posedge clk) begin
    if (tag_set) begin
      tag_mem[line_idx] <= line_tag;
    end
  end

  // Data array: synchronous word write
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_addr] <= wr_data;
    end
  end

  // Registered read of the looked-up word
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (rd_stb) begin
      rd_data_reg <= data_mem[lk_addr[IDX_W+OFF_W-1:0]];
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache on the MEM-stage port.
// Misses refill a whole line from backing memory over a req/ack handshake.
// Build macro DCACHE_STATS_EN adds saturating load hit/miss counters.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int ADDR_W = DC_ADDR_W,
  parameter int DATA_W = DC_DATA_W,
  parameter int LINES  = DC_LINES,
  parameter int WPL    = DC_WPL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              over,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rin,
  output logic [DATA_W-1:0] rout,
  output logic              rvalid,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] win,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int OFF_W = $clog2(WPL);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  state_t            state_reg, state_next;
  logic [OFF_W-1:0]  cnt_reg, req_off_reg;
  logic              mem_req_reg, mem_we_reg, hit_rv_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg, fill_word_reg;

  logic              hit, idle_act, do_store, do_hit, do_miss, ack, last_word, in_refill;
  logic [DATA_W-1:0] rd_word;

  assign in_refill = (state_reg == REFILL);
  assign idle_act  = (state_reg == IDLE) && !over;
  assign do_store  = idle_act && we;
  assign do_hit    = idle_act && !we && rd_en && hit;
  assign do_miss   = idle_act && !we && rd_en && !hit;
  assign ack       = mem_req_reg && mem_ack;
  assign last_word = (cnt_reg == OFF_W'(WPL - 1));

  // A store looks up its own address so a hit can update the line in place
  dcache_line_store #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINES(LINES), .WPL(WPL)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .lk_addr   (we ? waddr : rin),
    .hit       (hit),
    .rd_stb    (do_hit),
    .rd_data   (rd_word),
    .wr_en     ((do_store && hit) || (in_refill && ack)),
    .wr_addr   (in_refill ? mem_addr_reg[IDX_W+OFF_W-1:0] : waddr[IDX_W+OFF_W-1:0]),
    .wr_data   (in_refill ? mem_rdata : win),
    .tag_set   (in_refill && ack && last_word),
    .tag_inval (do_miss),
    .line_idx  (in_refill ? mem_addr_reg[OFF_W +: IDX_W] : rin[OFF_W +: IDX_W]),
    .line_tag  (mem_addr_reg[ADDR_W-1 -: TAG_W])
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (do_store)     state_next = WTHRU;
        else if (do_miss) state_next = REFILL;
      end
      WTHRU:   if (ack) state_next = IDLE;
      REFILL:  if (ack && last_word) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Backing-memory port, refill word counter and load-return registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      cnt_reg       <= '0;
      req_off_reg   <= '0;
      fill_word_reg <= '0;
      hit_rv_reg    <= 1'b0;
    end else begin
      hit_rv_reg <= do_hit;
      case (state_reg)
        IDLE: begin
          if (do_store) begin
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= waddr;
            mem_wdata_reg <= win;
          end else if (do_miss) begin
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= {rin[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            cnt_reg      <= '0;
            req_off_reg  <= rin[OFF_W-1:0];
          end
        end
        WTHRU: begin
          if (ack) begin
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
          end
        end
        REFILL: begin
          if (ack) begin
            // Keep the requested word aside so DONE can return it without a second read
            if (cnt_reg == req_off_reg) fill_word_reg <= mem_rdata;
            cnt_reg      <= cnt_reg + 1'b1;
            mem_addr_reg <= mem_addr_reg + 1'b1;
            if (last_word) mem_req_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_reg, miss_cnt_reg;

  // Saturating load hit / refill counters
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (do_hit && (hit_cnt_reg != 32'hFFFF_FFFF))   hit_cnt_reg  <= hit_cnt_reg + 1'b1;
      if (do_miss && (miss_cnt_reg != 32'hFFFF_FFFF)) miss_cnt_reg <= miss_cnt_reg + 1'b1;
    end
  end

  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

  assign stall     = (state_reg == WTHRU) || in_refill || do_store || do_miss;
  assign rvalid    = (state_reg == DONE) || hit_rv_reg;
  assign rout      = (state_reg == DONE) ? fill_word_reg : rd_word;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a backing-memory model that acks
// each request after two cycles; unwritten memory word k reads as A000_0000+k.
module tb_dcache_responder;

`ifdef DCACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, over, rd_en, we, mem_ack;
  logic [15:0] rin, waddr, mem_addr;
  logic [31:0] win, rout, mem_wdata, mem_rdata, hit_cnt, miss_cnt;
  logic        rvalid, stall, mem_req, mem_we;

  int          n_checks = 0;
  int          n_errors = 0;
  int          req_cycles = 0;
  logic [31:0] bmem [logic [15:0]];
  logic [15:0] rd_addrs [$];

  logic [31:0] d;
  bit          ok, first_stall, stall_all, hold_ok, found;

  dcache_responder dut (
    .clk(clk), .reset(reset), .over(over),
    .rd_en(rd_en), .rin(rin), .rout(rout), .rvalid(rvalid),
    .we(we), .waddr(waddr), .win(win), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Backing memory: ack on the second waiting cycle, for one cycle
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset || mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_req) begin
        req_cycles++;
        wait_cnt++;
        if (wait_cnt == 2) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            bmem[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : 32'hA000_0000 + 32'(mem_addr);
            rd_addrs.push_back(mem_addr);
          end
        end
      end
    end
  end

  // Issue one load and wait for rvalid; ends one idle cycle later
  task automatic do_load(input logic [15:0] a, output logic [31:0] data,
                         output bit got, output bit st_first, output bit st_all);
    rin = a; rd_en = 1'b1;
    #1;
    st_first = stall; st_all = 1'b1; got = 1'b0; data = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (rvalid) begin
        data = rout; got = 1'b1;
        break;
      end
      st_all &= stall;
    end
    rd_en = 1'b0;
    @(negedge clk); #1;
  endtask

  // Issue one store; drops we in the cycle whose edge completes the write-through
  task automatic do_store(input logic [15:0] a, input logic [31:0] v,
                          output bit hold, output bit got);
    waddr = a; win = v; we = 1'b1;
    #1;
    hold = stall; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      hold &= mem_req && mem_we && (mem_addr == a) && (mem_wdata == v);
      if (mem_req && mem_ack) begin
        got = 1'b1;
        break;
      end
    end
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; over = 1'b0; rd_en = 1'b0; we = 1'b0;
    rin = '0; waddr = '0; win = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rout", rout, 32'h0);
    check("rst_rvalid", {31'b0, rvalid}, 32'h0);
    check("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst_mem_addr", {16'b0, mem_addr}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_hit_cnt", hit_cnt, 32'h0);
    reset = 1'b0;
    @(negedge clk); #1;

    // Cold miss on 0x0012 refills 0x10..0x13
    rd_addrs.delete();
    do_load(16'h0012, d, ok, first_stall, stall_all);
    check("cold_done", {31'b0, ok}, 32'h1);
    check("cold_rout", d, 32'hA000_0012);
    check("cold_stall_first", {31'b0, first_stall}, 32'h1);
    check("cold_stall_all", {31'b0, stall_all}, 32'h1);
    check("cold_nreads", rd_addrs.size(), 32'd4);
    for (int i = 0; i < 4 && i < rd_addrs.size(); i++)
      check("cold_addr", {16'b0, rd_addrs[i]}, 32'h10 + 32'(i));
    check("cold_miss_cnt", miss_cnt, STATS ? 32'd1 : 32'd0);

    // Back-to-back hits 0x10..0x13
    req_cycles = 0;
    rin = 16'h0010; rd_en = 1'b1;
    #1;
    check("hit_stall", {31'b0, stall}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("hit_rvalid", {31'b0, rvalid}, 32'h1);
      check("hit_rout", rout, 32'hA000_0010 + 32'(i));
      rin = 16'h0011 + 16'(i);
    end
    rd_en = 1'b0;
    @(negedge clk); #1;
    check("hit_rvalid_off", {31'b0, rvalid}, 32'h0);
    check("hit_no_mem_req", req_cycles, 32'd0);
    check("hit_cnt4", hit_cnt, STATS ? 32'd4 : 32'd0);

    // Store hit to 0x0011, then load it back
    do_store(16'h0011, 32'hDEAD_BEEF, hold_ok, ok);
    check("st_done", {31'b0, ok}, 32'h1);
    check("st_hold", {31'b0, hold_ok}, 32'h1);
    @(negedge clk); #1;
    check("st_req_drop", {31'b0, mem_req}, 32'h0);
    check("st_mem_write", bmem.exists(16'h0011) ? bmem[16'h0011] : 32'h0, 32'hDEAD_BEEF);
    do_load(16'h0011, d, ok, first_stall, stall_all);
    check("st_load_hit", {31'b0, first_stall}, 32'h0);
    check("st_load_rout", d, 32'hDEAD_BEEF);

    // Store to uncached 0x0400: no allocate, the load misses and refills
    do_store(16'h0400, 32'h1234_5678, hold_ok, ok);
    check("na_st_hold", {31'b0, hold_ok & ok}, 32'h1);
    @(negedge clk); #1;
    rd_addrs.delete();
    do_load(16'h0400, d, ok, first_stall, stall_all);
    check("na_load_miss", {31'b0, first_stall}, 32'h1);
    check("na_load_rout", d, 32'h1234_5678);
    check("na_nreads", rd_addrs.size(), 32'd4);
    if (rd_addrs.size() == 4) begin
      check("na_first_addr", {16'b0, rd_addrs[0]}, 32'h0400);
      check("na_last_addr", {16'b0, rd_addrs[3]}, 32'h0403);
    end

    // Simultaneous store and load to 0x0011: store first, then hit with new data
    rin = 16'h0011; rd_en = 1'b1;
    do_store(16'h0011, 32'hCAFE_F00D, hold_ok, ok);
    check("sim_st", {31'b0, hold_ok & ok}, 32'h1);
    @(negedge clk); #1;
    check("sim_lookup_stall", {31'b0, stall}, 32'h0);
    @(negedge clk); #1;
    check("sim_rvalid", {31'b0, rvalid}, 32'h1);
    check("sim_rout", rout, 32'hCAFE_F00D);
    rd_en = 1'b0;
    @(negedge clk); #1;
    check("sim_hit_cnt", hit_cnt, STATS ? 32'd6 : 32'd0);
    check("sim_miss_cnt", miss_cnt, STATS ? 32'd2 : 32'd0);

    // over=1 ignores requests
    over = 1'b1; rin = 16'h0010; rd_en = 1'b1;
    #1;
    check("over_stall", {31'b0, stall}, 32'h0);
    @(negedge clk); #1;
    check("over_rvalid", {31'b0, rvalid}, 32'h0);
    check("over_mem_req", {31'b0, mem_req}, 32'h0);
    rd_en = 1'b0; over = 1'b0;
    @(negedge clk); #1;

    // Reset while the third refill word is outstanding
    rd_addrs.delete();
    rin = 16'h0020; rd_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (rd_addrs.size() >= 2 && mem_req && !mem_ack) begin
        found = 1'b1;
        break;
      end
    end
    check("rst3_reached", {31'b0, found}, 32'h1);
    check("rst3_addr", {16'b0, mem_addr}, 32'h0022);
    reset = 1'b1; rd_en = 1'b0;
    @(negedge clk); #1;
    check("rst3_mem_req", {31'b0, mem_req}, 32'h0);
    check("rst3_miss_cnt", miss_cnt, 32'h0);
    reset = 1'b0;
    @(negedge clk); #1;
    do_load(16'h0020, d, ok, first_stall, stall_all);
    check("rst3_reload_miss", {31'b0, first_stall}, 32'h1);
    check("rst3_reload_rout", d, 32'hA000_0020);
    check("rst3_reload_cnt", miss_cnt, STATS ? 32'd1 : 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
